// File: rtl/mmu_arbiter.sv
// ---------------------------------------------------------------------------
// mmu_arbiter
//
// Purpose:
//   Shares the single mmu_top read/write port between the instruction-fetch
//   path (read-only) and the load/store path (read or write). Only one
//   transaction is outstanding at a time. Each response goes back to the
//   requester that owns the transaction. A 1-bit round-robin pointer picks
//   the winner when both paths request together. The pointer favours
//   load/store out of reset.
//
// Optional feature (compile-time macro):
//   MMU_ARB_TIMEOUT_EN - adds a watchdog. If the MMU does not answer within
//   TIMEOUT_CYCLES cycles, the owner gets a *_valid pulse with arb_err=1 and
//   zeroed data/tag. Without the macro the wait states block indefinitely
//   and arb_err is tied to 0.
//
// Ports:
//   mmu_clk, i_rstn            clock, async active-low reset
//   if_req/if_addr             fetch request (level, held until if_gnt)
//   if_gnt/if_valid/if_data    fetch grant pulse, response pulse, read data
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_reg/ls_func3   load/store request and qualifiers
//   ls_gnt/ls_valid/ls_rdata/
//   ls_reg_out/ls_func3_out    load/store grant, completion, data and echoes
//   arb_err                    marks a *_valid pulse as a timeout
//   busy                       a transaction is outstanding
//   rd_*  (out)                read request to mmu_top
//   rd_valid/rd_data/
//   rd_valid_reg/rd_valid_func3 (in)  read response from mmu_top
//   wr_*  (out)                write request to mmu_top
//   wr_done/wr_done_reg (in)   write completion from mmu_top
// ---------------------------------------------------------------------------
module mmu_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              mmu_clk,
  input  logic              i_rstn,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  // load/store side
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [4:0]        ls_reg,
  input  logic [2:0]        ls_func3,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [4:0]        ls_reg_out,
  output logic [2:0]        ls_func3_out,
  // status
  output logic              arb_err,
  output logic              busy,
  // mmu_top read request / response
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [4:0]        rd_req_reg,
  output logic [2:0]        rd_req_func3,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [4:0]        rd_valid_reg,
  input  logic [2:0]        rd_valid_func3,
  // mmu_top write request / completion
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [4:0]        wr_req_reg,
  input  logic              wr_done,
  input  logic [4:0]        wr_done_reg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  // The fetch path always issues word reads with register tag 0.
  localparam logic [2:0] FETCH_FUNC3 = 3'b010;

  state_e              state_q, state_d;
  logic                prio_ls_q, prio_ls_d;
  logic                owner_ls_q, owner_ls_d;
  logic                grant_ls;

  logic                if_gnt_q, if_gnt_d;
  logic                ls_gnt_q, ls_gnt_d;
  logic                if_valid_q, if_valid_d;
  logic                ls_valid_q, ls_valid_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic [4:0]          ls_reg_out_q, ls_reg_out_d;
  logic [2:0]          ls_func3_out_q, ls_func3_out_d;

  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [4:0]          rd_req_reg_q, rd_req_reg_d;
  logic [2:0]          rd_req_func3_q, rd_req_func3_d;

  logic                wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [4:0]          wr_req_reg_q, wr_req_reg_d;

`ifdef MMU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                timeout_hit;
  logic                arb_err_q, arb_err_d;

  // The count after this cycle's increment; hitting the limit ends the wait.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`endif

  // A lone requester always wins. With both requesting, the pointer decides.
  assign grant_ls = ls_req && (!if_req || prio_ls_q);

  // Next-state and output logic. Pulse outputs default low. Latched request
  // fields and response data default to holding their value.
  always_comb begin
    state_d        = state_q;
    prio_ls_d      = prio_ls_q;
    owner_ls_d     = owner_ls_q;
    if_gnt_d       = 1'b0;
    ls_gnt_d       = 1'b0;
    if_valid_d     = 1'b0;
    ls_valid_d     = 1'b0;
    if_data_d      = if_data_q;
    ls_rdata_d     = ls_rdata_q;
    ls_reg_out_d   = ls_reg_out_q;
    ls_func3_out_d = ls_func3_out_q;
    rd_req_d       = 1'b0;
    rd_addr_d      = rd_addr_q;
    rd_req_reg_d   = rd_req_reg_q;
    rd_req_func3_d = rd_req_func3_q;
    wr_req_d       = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    wr_req_reg_d   = wr_req_reg_q;
`ifdef MMU_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    arb_err_d      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Responses arriving here are stale and are dropped.
        if (if_req || ls_req) begin
          owner_ls_d = grant_ls;
          // After a grant the other requester gets priority.
          prio_ls_d  = !grant_ls;
`ifdef MMU_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
          if (grant_ls) begin
            ls_gnt_d = 1'b1;
            if (ls_we) begin
              wr_req_d     = 1'b1;
              wr_addr_d    = ls_addr;
              wr_data_d    = ls_wdata;
              wr_req_reg_d = ls_reg;
              state_d      = WR_WAIT;
            end else begin
              rd_req_d       = 1'b1;
              rd_addr_d      = ls_addr;
              rd_req_reg_d   = ls_reg;
              rd_req_func3_d = ls_func3;
              state_d        = RD_WAIT;
            end
          end else begin
            if_gnt_d       = 1'b1;
            rd_req_d       = 1'b1;
            rd_addr_d      = if_addr;
            rd_req_reg_d   = 5'd0;
            rd_req_func3_d = FETCH_FUNC3;
            state_d        = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
`ifdef MMU_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (rd_valid) begin
          state_d = IDLE;
          if (owner_ls_q) begin
            ls_valid_d     = 1'b1;
            ls_rdata_d     = rd_data;
            ls_reg_out_d   = rd_valid_reg;
            ls_func3_out_d = rd_valid_func3;
          end else begin
            if_valid_d = 1'b1;
            if_data_d  = rd_data;
          end
        end
`ifdef MMU_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d   = IDLE;
          arb_err_d = 1'b1;
          if (owner_ls_q) begin
            ls_valid_d     = 1'b1;
            ls_rdata_d     = '0;
            ls_reg_out_d   = 5'd0;
            ls_func3_out_d = 3'd0;
          end else begin
            if_valid_d = 1'b1;
            if_data_d  = '0;
          end
        end
`endif
      end

      WR_WAIT: begin
`ifdef MMU_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        // Only load/store can own a write. func3 is not echoed for writes.
        if (wr_done) begin
          state_d        = IDLE;
          ls_valid_d     = 1'b1;
          ls_reg_out_d   = wr_done_reg;
          ls_func3_out_d = 3'd0;
        end
`ifdef MMU_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d        = IDLE;
          arb_err_d      = 1'b1;
          ls_valid_d     = 1'b1;
          ls_rdata_d     = '0;
          ls_reg_out_d   = 5'd0;
          ls_func3_out_d = 3'd0;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any outstanding transaction
  // and returns the pointer to favour load/store.
  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q        <= IDLE;
      prio_ls_q      <= 1'b1;
      owner_ls_q     <= 1'b0;
      if_gnt_q       <= 1'b0;
      ls_gnt_q       <= 1'b0;
      if_valid_q     <= 1'b0;
      ls_valid_q     <= 1'b0;
      if_data_q      <= '0;
      ls_rdata_q     <= '0;
      ls_reg_out_q   <= 5'd0;
      ls_func3_out_q <= 3'd0;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= '0;
      rd_req_reg_q   <= 5'd0;
      rd_req_func3_q <= 3'd0;
      wr_req_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_req_reg_q   <= 5'd0;
`ifdef MMU_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      arb_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      prio_ls_q      <= prio_ls_d;
      owner_ls_q     <= owner_ls_d;
      if_gnt_q       <= if_gnt_d;
      ls_gnt_q       <= ls_gnt_d;
      if_valid_q     <= if_valid_d;
      ls_valid_q     <= ls_valid_d;
      if_data_q      <= if_data_d;
      ls_rdata_q     <= ls_rdata_d;
      ls_reg_out_q   <= ls_reg_out_d;
      ls_func3_out_q <= ls_func3_out_d;
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      rd_req_reg_q   <= rd_req_reg_d;
      rd_req_func3_q <= rd_req_func3_d;
      wr_req_q       <= wr_req_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_req_reg_q   <= wr_req_reg_d;
`ifdef MMU_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      arb_err_q      <= arb_err_d;
`endif
    end
  end

  assign if_gnt       = if_gnt_q;
  assign ls_gnt       = ls_gnt_q;
  assign if_valid     = if_valid_q;
  assign ls_valid     = ls_valid_q;
  assign if_data      = if_data_q;
  assign ls_rdata     = ls_rdata_q;
  assign ls_reg_out   = ls_reg_out_q;
  assign ls_func3_out = ls_func3_out_q;
  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign rd_req_reg   = rd_req_reg_q;
  assign rd_req_func3 = rd_req_func3_q;
  assign wr_req       = wr_req_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_req_reg   = wr_req_reg_q;
  assign busy         = (state_q != IDLE);

`ifdef MMU_ARB_TIMEOUT_EN
  assign arb_err = arb_err_q;
`else
  // The watchdog limit has no meaning in this build.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_mmu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmu_arbiter
//
// Self-checking bench for mmu_arbiter. The bench plays the role of mmu_top.
// Whenever it drives a response, it pushes the response it expects the
// arbiter to return onto a scoreboard queue. It pops that entry when
// if_valid or ls_valid appears. If MMU_ARB_TIMEOUT_EN is defined, the
// watchdog scenario also runs, with TIMEOUT_CYCLES = 16.
// ---------------------------------------------------------------------------
module tb_mmu_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          mmu_clk = 1'b0;
  logic          i_rstn;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_valid;
  logic [DW-1:0] if_data;
  logic          ls_req, ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [4:0]    ls_reg;
  logic [2:0]    ls_func3;
  logic          ls_gnt, ls_valid;
  logic [DW-1:0] ls_rdata;
  logic [4:0]    ls_reg_out;
  logic [2:0]    ls_func3_out;
  logic          arb_err, busy;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [4:0]    rd_req_reg;
  logic [2:0]    rd_req_func3;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [4:0]    rd_valid_reg;
  logic [2:0]    rd_valid_func3;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [4:0]    wr_req_reg;
  logic          wr_done;
  logic [4:0]    wr_done_reg;

  typedef struct packed {
    logic          is_ls;
    logic [DW-1:0] data;
    logic [4:0]    tag;
    logic [2:0]    f3;
    logic          err;
    logic          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 mmu_clk = ~mmu_clk;

  mmu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .mmu_clk(mmu_clk), .i_rstn(i_rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_reg(ls_reg),
    .ls_func3(ls_func3), .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .ls_reg_out(ls_reg_out), .ls_func3_out(ls_func3_out), .arb_err(arb_err), .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_req_reg(rd_req_reg), .rd_req_func3(rd_req_func3),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_valid_reg(rd_valid_reg), .rd_valid_func3(rd_valid_func3),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_req_reg(wr_req_reg),
    .wr_done(wr_done), .wr_done_reg(wr_done_reg)
  );

  // Reset, then 20 idle cycles with every output expected at 0.
  task automatic test_reset();
    i_rstn = 1'b0; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0;
    ls_wdata = '0; ls_reg = '0; ls_func3 = '0; rd_valid = 0; rd_data = '0;
    rd_valid_reg = '0; rd_valid_func3 = '0; wr_done = 0; wr_done_reg = '0;
    repeat (3) @(negedge mmu_clk);
    i_rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge mmu_clk);
      checks++;
      if ({if_gnt, if_valid, if_data, ls_gnt, ls_valid, ls_rdata, ls_reg_out, ls_func3_out,
           arb_err, busy, rd_req, rd_addr, rd_req_reg, rd_req_func3, wr_req, wr_addr,
           wr_data, wr_req_reg} !== '0)
        $display("[TB] FAIL reset_idle cycle %0d: busy=%b gnt=%b%b rd_req=%b wr_req=%b, required all 0",
                 i, busy, if_gnt, ls_gnt, rd_req, wr_req);
      else passes++;
    end
  endtask

  // Lone fetch read, MMU answers after 6 cycles.
  task automatic test_lone_fetch();
    exp_t e;
    int   extra = 0;
    @(negedge mmu_clk);
    if_req = 1; if_addr = 32'h0000_1000;
    @(negedge mmu_clk);
    checks++;
    if ({if_gnt, ls_gnt, rd_req, wr_req, busy} !== 5'b10101)
      $display("[TB] FAIL fetch_grant: gnt/ls_gnt/rd_req/wr_req/busy=%b required 10101",
               {if_gnt, ls_gnt, rd_req, wr_req, busy});
    else passes++;
    checks++;
    if ({rd_addr, rd_req_reg, rd_req_func3} !== {32'h0000_1000, 5'd0, 3'b010})
      $display("[TB] FAIL fetch_rd_fields: addr=%h reg=%0d f3=%b required 1000/0/010",
               rd_addr, rd_req_reg, rd_req_func3);
    else passes++;
    if_req = 0; if_addr = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge mmu_clk);
      if (if_gnt || ls_gnt || rd_req || if_valid || ls_valid || !busy) extra++;
    end
    checks++;
    if (extra !== 0) $display("[TB] FAIL fetch_wait_quiet: %0d bad cycles required 0", extra);
    else passes++;
    rd_valid = 1; rd_data = 32'hDEAD_BEEF; rd_valid_reg = 5'd9; rd_valid_func3 = 3'b111;
    exp_q.push_back('{is_ls: 1'b0, data: 32'hDEAD_BEEF, tag: 5'd0, f3: 3'd0, err: 1'b0, chk_data: 1'b1});
    @(negedge mmu_clk);
    rd_valid = 0;
    e = exp_q.pop_front();
    checks++;
    if ({if_valid, ls_valid, arb_err} !== {!e.is_ls, e.is_ls, e.err})
      $display("[TB] FAIL fetch_valid: if/ls/err=%b required %b",
               {if_valid, ls_valid, arb_err}, {!e.is_ls, e.is_ls, e.err});
    else passes++;
    checks++;
    if (if_data !== e.data) $display("[TB] FAIL fetch_data: got %h required %h", if_data, e.data);
    else passes++;
    @(negedge mmu_clk);
    checks++;
    if ({if_valid, busy} !== 2'b00) $display("[TB] FAIL fetch_done: valid/busy=%b required 00", {if_valid, busy});
    else passes++;
  endtask

  // Both requesters held from reset: strict alternation starting with ls.
  task automatic test_round_robin();
    exp_t e;
    logic exp_ls = 1'b1;
    logic got;
    int   waited;
    i_rstn = 1'b0;
    if_req = 1; if_addr = 32'h0000_0400;
    ls_req = 1; ls_we = 0; ls_addr = 32'h0000_0300; ls_reg = 5'd7; ls_func3 = 3'b100;
    repeat (2) @(negedge mmu_clk);
    i_rstn = 1'b1;
    for (int t = 0; t < 10; t++) begin
      got = 0; waited = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge mmu_clk);
        waited++;
        if (if_gnt || ls_gnt) begin got = 1; break; end
      end
      checks++;
      if (!got) begin
        $display("[TB] FAIL rr_grant_timeout txn %0d: no grant in 8 cycles, required one", t);
        break;
      end else passes++;
      checks++;
      if ({ls_gnt, if_gnt} !== {exp_ls, !exp_ls})
        $display("[TB] FAIL rr_order txn %0d: ls_gnt/if_gnt=%b%b required %b%b", t, ls_gnt, if_gnt, exp_ls, !exp_ls);
      else passes++;
      checks++;
      if ({rd_req, rd_addr, rd_req_reg, rd_req_func3} !==
          {1'b1, (exp_ls ? 32'h0000_0300 : 32'h0000_0400), (exp_ls ? 5'd7 : 5'd0), (exp_ls ? 3'b100 : 3'b010)})
        $display("[TB] FAIL rr_rd_fields txn %0d: req=%b addr=%h reg=%0d f3=%b", t, rd_req, rd_addr, rd_req_reg, rd_req_func3);
      else passes++;
      if (t > 0) begin
        checks++;
        if (waited !== 1) $display("[TB] FAIL rr_back_to_back txn %0d: grant after %0d cycles required 1", t, waited);
        else passes++;
      end
      repeat (2) @(negedge mmu_clk);
      rd_valid = 1; rd_data = 32'hA000_0000 + t;
      rd_valid_reg = exp_ls ? 5'd7 : 5'd0; rd_valid_func3 = exp_ls ? 3'b100 : 3'b000;
      exp_q.push_back('{is_ls: exp_ls, data: 32'hA000_0000 + t, tag: 5'd7, f3: 3'b100, err: 1'b0, chk_data: 1'b1});
      @(negedge mmu_clk);
      rd_valid = 0;
      if (t == 9) begin if_req = 0; ls_req = 0; end
      e = exp_q.pop_front();
      checks++;
      if ({if_valid, ls_valid, arb_err, if_gnt, ls_gnt} !== {!e.is_ls, e.is_ls, e.err, 2'b00})
        $display("[TB] FAIL rr_valid txn %0d: if/ls/err/gnts=%b required %b", t,
                 {if_valid, ls_valid, arb_err, if_gnt, ls_gnt}, {!e.is_ls, e.is_ls, e.err, 2'b00});
      else passes++;
      checks++;
      if ((e.is_ls ? {ls_rdata, ls_reg_out, ls_func3_out} : {if_data, 5'd7, 3'b100}) !== {e.data, e.tag, e.f3})
        $display("[TB] FAIL rr_data txn %0d: data=%h tag=%0d f3=%b required %h/%0d/%b", t,
                 e.is_ls ? ls_rdata : if_data, ls_reg_out, ls_func3_out, e.data, e.tag, e.f3);
      else passes++;
      exp_ls = !exp_ls;
    end
    @(negedge mmu_clk);
    checks++;
    if ({busy, if_gnt, ls_gnt} !== 3'b000) $display("[TB] FAIL rr_drain: busy/gnts=%b required 000", {busy, if_gnt, ls_gnt});
    else passes++;
  endtask

  // Store with a spurious read response during WR_WAIT.
  task automatic test_write();
    exp_t e;
    @(negedge mmu_clk);
    ls_req = 1; ls_we = 1; ls_addr = 32'h0000_0200; ls_wdata = 32'h1234_5678; ls_reg = 5'd3; ls_func3 = 3'b010;
    @(negedge mmu_clk);
    checks++;
    if ({ls_gnt, if_gnt, wr_req, rd_req, busy} !== 5'b10101)
      $display("[TB] FAIL wr_grant: ls_gnt/if_gnt/wr_req/rd_req/busy=%b required 10101", {ls_gnt, if_gnt, wr_req, rd_req, busy});
    else passes++;
    checks++;
    if ({wr_addr, wr_data, wr_req_reg} !== {32'h0000_0200, 32'h1234_5678, 5'd3})
      $display("[TB] FAIL wr_fields: addr=%h data=%h reg=%0d required 200/12345678/3", wr_addr, wr_data, wr_req_reg);
    else passes++;
    ls_req = 0; ls_we = 0;
    rd_valid = 1; rd_data = 32'hBAD0_BAD0; rd_valid_reg = 5'd9; rd_valid_func3 = 3'b001;
    @(negedge mmu_clk);
    rd_valid = 0;
    checks++;
    if ({wr_req, if_valid, ls_valid, busy} !== 4'b0001)
      $display("[TB] FAIL wr_spurious_rd: wr_req/if_valid/ls_valid/busy=%b required 0001", {wr_req, if_valid, ls_valid, busy});
    else passes++;
    @(negedge mmu_clk);
    wr_done = 1; wr_done_reg = 5'd3;
    exp_q.push_back('{is_ls: 1'b1, data: '0, tag: 5'd3, f3: 3'd0, err: 1'b0, chk_data: 1'b0});
    @(negedge mmu_clk);
    wr_done = 0;
    e = exp_q.pop_front();
    checks++;
    if ({if_valid, ls_valid, arb_err, ls_reg_out, ls_func3_out} !== {!e.is_ls, e.is_ls, e.err, e.tag, e.f3})
      $display("[TB] FAIL wr_done: if/ls/err=%b tag=%0d f3=%b required ls pulse, tag %0d, f3 0",
               {if_valid, ls_valid, arb_err}, ls_reg_out, ls_func3_out, e.tag);
    else passes++;
    @(negedge mmu_clk);
    checks++;
    if ({ls_valid, busy} !== 2'b00) $display("[TB] FAIL wr_idle: valid/busy=%b required 00", {ls_valid, busy});
    else passes++;
  endtask

  // Reset in RD_WAIT, then a late response that must be dropped.
  task automatic test_reset_mid();
    exp_t e;
    @(negedge mmu_clk);
    if_req = 1; if_addr = 32'h0000_0800;
    @(negedge mmu_clk);
    if_req = 0;
    checks++;
    if ({if_gnt, busy} !== 2'b11) $display("[TB] FAIL rm_grant: gnt/busy=%b required 11", {if_gnt, busy});
    else passes++;
    repeat (2) @(negedge mmu_clk);
    i_rstn = 1'b0;
    #1;
    checks++;
    if ({busy, rd_req, if_valid, ls_valid, rd_addr} !== '0)
      $display("[TB] FAIL rm_in_reset: busy=%b addr=%h required 0", busy, rd_addr);
    else passes++;
    @(negedge mmu_clk);
    i_rstn = 1'b1;
    rd_valid = 1; rd_data = 32'h0000_FACE;
    @(negedge mmu_clk);
    rd_valid = 0;
    checks++;
    if ({if_valid, ls_valid, busy, if_data} !== '0)
      $display("[TB] FAIL rm_late_resp: if/ls/busy=%b data=%h required all 0", {if_valid, ls_valid, busy}, if_data);
    else passes++;
    if_req = 1; if_addr = 32'h0000_0900;
    @(negedge mmu_clk);
    if_req = 0;
    checks++;
    if ({if_gnt, ls_gnt, busy, rd_addr} !== {3'b101, 32'h0000_0900})
      $display("[TB] FAIL rm_regrant: gnt/ls_gnt/busy=%b addr=%h required 101/900", {if_gnt, ls_gnt, busy}, rd_addr);
    else passes++;
    rd_valid = 1; rd_data = 32'h0000_900D;
    exp_q.push_back('{is_ls: 1'b0, data: 32'h0000_900D, tag: 5'd0, f3: 3'd0, err: 1'b0, chk_data: 1'b1});
    @(negedge mmu_clk);
    rd_valid = 0;
    e = exp_q.pop_front();
    checks++;
    if ({if_valid, ls_valid, arb_err, if_data} !== {!e.is_ls, e.is_ls, e.err, e.data})
      $display("[TB] FAIL rm_resp: if/ls/err=%b data=%h required 100/%h", {if_valid, ls_valid, arb_err}, if_data, e.data);
    else passes++;
    @(negedge mmu_clk);
  endtask

`ifdef MMU_ARB_TIMEOUT_EN
  // The MMU never answers: the watchdog completes the fetch with an error.
  task automatic test_timeout();
    exp_t e;
    logic got = 0;
    int   cnt = 0;
    @(negedge mmu_clk);
    if_req = 1; if_addr = 32'h0000_0A00;
    @(negedge mmu_clk);
    if_req = 0;
    checks++;
    if (if_gnt !== 1'b1) $display("[TB] FAIL to_grant: got %b required 1", if_gnt);
    else passes++;
    exp_q.push_back('{is_ls: 1'b0, data: '0, tag: 5'd0, f3: 3'd0, err: 1'b1, chk_data: 1'b1});
    for (int k = 0; k < 40; k++) begin
      @(negedge mmu_clk);
      cnt++;
      if (if_valid || ls_valid) begin got = 1; break; end
    end
    e = exp_q.pop_front();
    checks++;
    if (!got || cnt !== 16)
      $display("[TB] FAIL to_latency: valid seen=%b after %0d cycles required 16", got, cnt);
    else passes++;
    checks++;
    if ({if_valid, ls_valid, arb_err, if_data} !== {!e.is_ls, e.is_ls, e.err, e.data})
      $display("[TB] FAIL to_resp: if/ls/err=%b data=%h required 101/0", {if_valid, ls_valid, arb_err}, if_data);
    else passes++;
    @(negedge mmu_clk);
    checks++;
    if ({arb_err, busy, if_valid} !== 3'b000) $display("[TB] FAIL to_idle: err/busy/valid=%b required 000", {arb_err, busy, if_valid});
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_lone_fetch();
    test_round_robin();
    test_write();
    test_reset_mid();
`ifdef MMU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] aborted");
  end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Two-requester arbiter in front of `mmu_top`. It shares the single MMU read/write port between the instruction-fetch path (read-only) and the load/store path (read or write). It allows one outstanding transaction at a time and routes each response back to its owner. It sits between the core front-end/LSU and `mmu_top`, and it is clocked by the MMU clock.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 1024, watchdog limit in cycles (used only with `MMU_ARB_TIMEOUT_EN`)

Ports (one clock `mmu_clk`; reset `i_rstn` is asynchronous and active-low):
- `mmu_clk` in 1: clock
- `i_rstn` in 1: async active-low reset
- `if_req` in 1: fetch read request, level; held with `if_addr` until `if_gnt`
- `if_addr` in ADDR_W: fetch address
- `if_gnt` out 1: one-cycle grant pulse to fetch
- `if_valid` out 1: one-cycle response pulse to fetch
- `if_data` out DATA_W: fetch read data
- `ls_req` in 1: load/store request, level; held with its qualifiers until `ls_gnt`
- `ls_we` in 1: 1 = write, 0 = read
- `ls_addr` in ADDR_W: load/store address
- `ls_wdata` in DATA_W: store data
- `ls_reg` in 5: destination/source register tag
- `ls_func3` in 3: access size code
- `ls_gnt` out 1: one-cycle grant pulse to load/store
- `ls_valid` out 1: one-cycle pulse; read data valid, or write done
- `ls_rdata` out DATA_W: load data
- `ls_reg_out` out 5: tag echoed from the MMU
- `ls_func3_out` out 3: func3 echoed from the MMU (0 for writes)
- `arb_err` out 1: qualifies `if_valid`/`ls_valid` as a timeout; constant 0 without the macro
- `busy` out 1: transaction outstanding
- `rd_req`, `rd_addr`, `rd_req_reg`, `rd_req_func3` out: connect to `mmu_top` read request
- `rd_valid`, `rd_data`, `rd_valid_reg`, `rd_valid_func3` in: connect to `mmu_top` read response
- `wr_req`, `wr_addr`, `wr_data`, `wr_req_reg` out: connect to `mmu_top` write request
- `wr_done`, `wr_done_reg` in: connect to `mmu_top` write completion

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE with no request: remain in IDLE.
- IDLE with at least one request: pick a winner, latch its address, data, tag and func3, and pulse the winner's `*_gnt`.
  - If the winner issues a read: pulse `rd_req` and go to RD_WAIT.
  - If the winner issues a write (`ls_we`=1): pulse `wr_req` and go to WR_WAIT.
- Fetch reads drive `rd_req_reg`=0 and `rd_req_func3`=3'b010.
- RD_WAIT:
  - On `rd_valid`, register `rd_data`, `rd_valid_reg` and `rd_valid_func3` to the owner, pulse the owner's `*_valid`, and go to IDLE.
  - `wr_done` is ignored in this state.
- WR_WAIT:
  - On `wr_done`, pulse `ls_valid` with `ls_reg_out`=`wr_done_reg` and `ls_func3_out`=0, and go to IDLE.
  - `rd_valid` is ignored in this state.
- Arbitration is round-robin through a 1-bit pointer.
  - The pointer favours ls out of reset.
  - After every grant, the pointer favours the other requester.
  - A lone requester always wins.
- `rd_addr`, `wr_addr` and `wr_data` hold their latched values until the next grant.
- `busy` = (state != IDLE).
- A `rd_valid` or `wr_done` arriving in IDLE is dropped with no output.

## Timing
- Request sampled high at edge N (state IDLE): `*_gnt`, `rd_req`/`wr_req` and `busy` are high for the cycle after N. `rd_req` and `wr_req` are single-cycle pulses.
- MMU response sampled at edge M: owner `*_valid` is high for the cycle after M, and the state is IDLE after M.
- Next grant is at edge M+1 at the earliest. Back-to-back throughput is one transaction per (MMU latency + 2) cycles.
- A response and a new request in the same cycle: the response completes first; the request is arbitrated in the following IDLE cycle.
- Reset values: all outputs are 0, state is IDLE, and the pointer favours ls.
- Reset asserted mid-transaction: the transaction is abandoned, no `*_valid` is issued, and a late MMU response after reset is dropped in IDLE.

## Configuration
- `MMU_ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on grant and increments in RD_WAIT/WR_WAIT.
  - When it reaches TIMEOUT_CYCLES, the owner's `*_valid` pulses with `arb_err`=1 and data/tag outputs at 0, and the state returns to IDLE.
  - `arb_err` is otherwise 0 and is high only alongside a `*_valid` pulse.
- `MMU_ARB_TIMEOUT_EN` undefined: there is no counter, the wait states block indefinitely, and `arb_err` is tied 0.

## Test plan
- Reset release, no requests -> all outputs 0, `busy`=0 for 20 cycles.
- Lone `if_req` with `if_addr`=0x0000_1000, MMU returns `rd_data`=0xDEAD_BEEF after 6 cycles -> one `if_gnt` and one `rd_req` pulse, `rd_addr`=0x1000, `rd_req_func3`=3'b010, then `if_valid`=1 with `if_data`=0xDEAD_BEEF one cycle after `rd_valid`.
- `if_req` and `ls_req` (read, `ls_reg`=5'd7) both held from reset -> ls granted first, fetch granted second; `ls_reg_out`=7 echoed; grants strictly alternate over 10 transactions.
- `ls_req` write to 0x200 with data 0x1234_5678 and `ls_reg`=3 -> `wr_req` pulse, `wr_data`=0x1234_5678; `wr_done` with `wr_done_reg`=3 gives `ls_valid` with `ls_reg_out`=3; a spurious `rd_valid` during WR_WAIT has no effect.
- `i_rstn` pulled low in RD_WAIT, then `rd_valid` driven after release -> no `*_valid` output, `busy`=0, next `if_req` granted normally.
- With `MMU_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, MMU never responds -> `if_valid`=1 and `arb_err`=1 with `if_data`=0 at cycle 16 after grant, then IDLE.
